uart_tx_param: RTL

Parametrised transmit-only UART: next generation of the team's fixed 8N1 transmitter.
- Configurable data width, parity mode, stop-bit count and FIFO depth.
- Integrated baud-tick divider; no external clock generator or edge detector.
- Exposes FIFO status and an overflow pulse.
- Sits between any byte producer (e.g. a packetiser) and the board TX pin.

---
 rtl/uart_tx_param_if.sv | 27 ++
 rtl/uart_tx_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param_if.sv
// Write-side bundle of the parametrised UART transmitter: producer data/strobe
// towards the FIFO and the FIFO status flags back to the producer.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_i;
    logic                 wr_en_i;
    logic                 full_o;
    logic                 empty_o;
    logic                 overflow_o;

    modport master (
        output data_i,
        output wr_en_i,
        input  full_o,
        input  empty_o,
        input  overflow_o
    );

    modport slave (
        input  data_i,
        input  wr_en_i,
        output full_o,
        output empty_o,
        output overflow_o
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised transmit-only UART: write FIFO, integrated baud divider and a
// START/DATA/PARITY/STOP framing FSM driving a registered serial line.
module uart_tx_param #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD           = 115_200,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_SIZE_POW2 = 3
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_param_if.slave bus,
    output logic           busy_o,
    output logic           tx_o
);
    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DEPTH = 2 ** FIFO_SIZE_POW2;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW    = (FIFO_SIZE_POW2 > 0) ? FIFO_SIZE_POW2 : 1;
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_param: CLK_FREQ/BAUD must round to at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_SIZE_POW2 < 1) begin : g_bad_fifo
        $error("uart_tx_param: FIFO_SIZE_POW2 must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    // Even parity is the XOR of the data bits; odd parity is its complement.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [PW:0]          count_r, count_next_s;
    logic                 full_r, empty_r, overflow_r;
    logic                 push_s, pop_s;
    logic [DATA_BITS-1:0] fifo_head_s;

    state_t               state_r, state_next_s;
    logic [CW-1:0]        baud_cnt_r;
    logic                 bit_done_s;
    logic [DATA_BITS-1:0] shift_r, shift_next_s;
    logic [3:0]           bit_idx_r, bit_idx_next_s;
    logic                 stop_idx_r, stop_idx_next_s;
    logic                 parity_r, parity_next_s;
    logic                 tx_r, tx_next_s;
    logic                 busy_r;

    assign push_s       = bus.wr_en_i && !full_r;
    assign count_next_s = count_r + (PW+1)'(push_s) - (PW+1)'(pop_s);
    assign fifo_head_s  = mem_r[rd_ptr_r];
    assign bit_done_s   = (state_r != ST_IDLE) && (baud_cnt_r == LAST_CNT);

    // FIFO storage; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.data_i;
        end
    end

    // FIFO pointers, occupancy and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r    <= count_next_s;
            full_r     <= (count_next_s == (PW+1)'(DEPTH));
            empty_r    <= (count_next_s == '0);
            // A write against a full FIFO is dropped even if a pop frees a slot now.
            overflow_r <= bus.wr_en_i && full_r;
        end
    end

    // Baud divider: free-runs 0..DIV-1 while a frame is on the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_r <= '0;
        end else if (state_r == ST_IDLE || bit_done_s) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + CW'(1);
        end
    end

    // Framing FSM next-state, FIFO pop and datapath loads.
    always_comb begin
        state_next_s    = state_r;
        shift_next_s    = shift_r;
        bit_idx_next_s  = bit_idx_r;
        stop_idx_next_s = stop_idx_r;
        parity_next_s   = parity_r;
        pop_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s         = 1'b1;
                    shift_next_s  = fifo_head_s;
                    parity_next_s = frame_parity(fifo_head_s);
                    state_next_s  = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_next_s   = ST_DATA;
                    bit_idx_next_s = 4'd0;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    shift_next_s = shift_r >> 1;
                    if (bit_idx_r == LAST_BIT) begin
                        stop_idx_next_s = 1'b0;
                        state_next_s    = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next_s = bit_idx_r + 4'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    stop_idx_next_s = 1'b0;
                    state_next_s    = ST_STOP;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    if (stop_idx_r == LAST_STOP) begin
                        // Chain straight into the next start bit when more data waits.
                        if (!empty_r) begin
                            pop_s         = 1'b1;
                            shift_next_s  = fifo_head_s;
                            parity_next_s = frame_parity(fifo_head_s);
                            state_next_s  = ST_START;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end else begin
                        stop_idx_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx_o is a pure flop output.
    always_comb begin
        tx_next_s = 1'b1;
        case (state_next_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = parity_next_s;
            ST_IDLE:   tx_next_s = 1'b1;
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // FSM state, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            shift_r    <= shift_next_s;
            bit_idx_r  <= bit_idx_next_s;
            stop_idx_r <= stop_idx_next_s;
            parity_r   <= parity_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    assign tx_o           = tx_r;
    assign busy_o         = busy_r;
    assign bus.full_o     = full_r;
    assign bus.empty_o    = empty_r;
    assign bus.overflow_o = overflow_r;
endmodule
